keycode_action_decoder: RTL and testbench



---
 rtl/keycode_action_decoder.sv | 124 ++++++++++++
 tb/tb_keycode_action_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keycode_action_decoder.sv
// Decodes the HID keycode word into per-player, frame-aligned tank actions and fire events.
// Optional macro ROLLOVER_FILTER_EN freezes all action state on frames reporting ErrorRollOver (0x01).
module keycode_action_decoder #(
  parameter int SLOTS         = 4,
  parameter int PLAYERS       = 2,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [8*SLOTS-1:0]   keycode,
  input  logic                 frame_vs,
  output logic                 frame_tick,
  output logic [PLAYERS-1:0]   move_fwd,
  output logic [PLAYERS-1:0]   move_back,
  output logic [PLAYERS-1:0]   rot_left,
  output logic [PLAYERS-1:0]   rot_right,
  output logic [PLAYERS-1:0]   fire_pulse
);

  localparam int RW = (REPEAT_FRAMES == 0) ? 1 : $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'((REPEAT_FRAMES == 0) ? 0 : REPEAT_FRAMES - 1);
  localparam logic [RW-1:0] RPT_MAX  = '1;

  // Action order within each byte lane: fwd, back, left, right, fire (lane 0 = fwd).
  localparam logic [39:0] P0_MAP = {8'h2C, 8'h07, 8'h04, 8'h16, 8'h1A};
  localparam logic [39:0] P1_MAP = {8'h28, 8'h4F, 8'h50, 8'h51, 8'h52};

  logic [8*SLOTS-1:0]           kc_q;
  logic                         vs_s1, vs_s2, vs_hist;
  logic [PLAYERS-1:0][4:0]      pressed;
  logic [PLAYERS-1:0]           dir_fwd, dir_back, dir_left, dir_right;
  logic [PLAYERS-1:0]           prev_fire;
  logic [PLAYERS-1:0][RW-1:0]   rpt_cnt;
  logic                         hold;

  function automatic logic [7:0] key_code(input int p, input int a);
    logic [39:0] map;
    map = (p == 0) ? P0_MAP : P1_MAP;
    return map[8*a +: 8];
  endfunction

  always_comb begin
    pressed = '0;
    hold    = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
`ifdef ROLLOVER_FILTER_EN
      if (kc_q[8*s +: 8] == 8'h01) hold = 1'b1;
`endif
      for (int p = 0; p < PLAYERS; p++) begin
        for (int a = 0; a < 5; a++) begin
          if (kc_q[8*s +: 8] == key_code(p, a)) pressed[p][a] = 1'b1;
        end
      end
    end
  end

  // Opposing keys cancel each other; orthogonal keys combine freely.
  always_comb begin
    dir_fwd   = '0;
    dir_back  = '0;
    dir_left  = '0;
    dir_right = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      dir_fwd[p]   = pressed[p][0] & ~pressed[p][1];
      dir_back[p]  = pressed[p][1] & ~pressed[p][0];
      dir_left[p]  = pressed[p][2] & ~pressed[p][3];
      dir_right[p] = pressed[p][3] & ~pressed[p][2];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q       <= '0;
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_hist    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      kc_q       <= keycode;
      vs_s1      <= frame_vs;
      vs_s2      <= vs_s1;
      vs_hist    <= vs_s2;
      frame_tick <= vs_hist & ~vs_s2;
    end
  end

  // All actions are sampled on the tick cycle so the game logic sees one stable value per frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      move_fwd   <= '0;
      move_back  <= '0;
      rot_left   <= '0;
      rot_right  <= '0;
      fire_pulse <= '0;
      prev_fire  <= '0;
      rpt_cnt    <= '0;
    end else begin
      fire_pulse <= '0;
      if (frame_tick && !hold) begin
        move_fwd  <= dir_fwd;
        move_back <= dir_back;
        rot_left  <= dir_left;
        rot_right <= dir_right;
        for (int p = 0; p < PLAYERS; p++) begin
          prev_fire[p] <= pressed[p][4];
          if (pressed[p][4]) begin
            if (!prev_fire[p]) begin
              fire_pulse[p] <= 1'b1;
              rpt_cnt[p]    <= '0;
            end else if (REPEAT_FRAMES != 0 && rpt_cnt[p] == RPT_LAST) begin
              fire_pulse[p] <= 1'b1;
              rpt_cnt[p]    <= '0;
            end else if (rpt_cnt[p] != RPT_MAX) begin
              rpt_cnt[p]    <= rpt_cnt[p] + RW'(1);
            end
          end else begin
            rpt_cnt[p] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keycode_action_decoder.sv
// Self-checking bench: two decoder configurations driven by frame-level directed and random keycodes.
`timescale 1ns/1ps
module tb_keycode_action_decoder;

  logic        Clk;
  logic        Reset;
  logic        frame_vs;
  logic [31:0] keycode;

  logic        frame_tick;
  logic [1:0]  move_fwd, move_back, rot_left, rot_right, fire_pulse;
  logic        frame_tick1;
  logic [0:0]  move_fwd1, move_back1, rot_left1, rot_right1, fire_pulse1;

  int checks = 0;
  int failures = 0;
  int pulseCount = 0;

  int         held [2][2];
  logic [7:0] expDir [2];
  logic [1:0] expFire [2];

  keycode_action_decoder #(.SLOTS(4), .PLAYERS(2), .REPEAT_FRAMES(8)) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_vs(frame_vs),
    .frame_tick(frame_tick), .move_fwd(move_fwd), .move_back(move_back),
    .rot_left(rot_left), .rot_right(rot_right), .fire_pulse(fire_pulse)
  );

  keycode_action_decoder #(.SLOTS(2), .PLAYERS(1), .REPEAT_FRAMES(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .keycode(keycode[15:0]), .frame_vs(frame_vs),
    .frame_tick(frame_tick1), .move_fwd(move_fwd1), .move_back(move_back1),
    .rot_left(rot_left1), .rot_right(rot_right1), .fire_pulse(fire_pulse1)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  function automatic logic [7:0] keyOf(input int p, input int a);
    case (p * 5 + a)
      0: return 8'h1A;
      1: return 8'h16;
      2: return 8'h04;
      3: return 8'h07;
      4: return 8'h2C;
      5: return 8'h52;
      6: return 8'h51;
      7: return 8'h50;
      8: return 8'h4F;
      9: return 8'h28;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit hasCode(input logic [31:0] kc, input int slots, input logic [7:0] code);
    for (int s = 0; s < slots; s++)
      if (kc[8*s +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  // Frame-level reference: which keys are down this frame, and how many frames fire has been held.
  task automatic modelFrame(input logic [31:0] kc);
    int slots, players, rep;
    bit f, b, l, r;
    for (int c = 0; c < 2; c++) begin
      slots   = (c == 0) ? 4 : 2;
      players = (c == 0) ? 2 : 1;
      rep     = (c == 0) ? 8 : 0;
      expFire[c] = '0;
`ifdef ROLLOVER_FILTER_EN
      if (hasCode(kc, slots, 8'h01)) continue;
`endif
      expDir[c] = '0;
      for (int p = 0; p < players; p++) begin
        f = hasCode(kc, slots, keyOf(p, 0));
        b = hasCode(kc, slots, keyOf(p, 1));
        l = hasCode(kc, slots, keyOf(p, 2));
        r = hasCode(kc, slots, keyOf(p, 3));
        expDir[c][6+p] = f && !b;
        expDir[c][4+p] = b && !f;
        expDir[c][2+p] = l && !r;
        expDir[c][p]   = r && !l;
        if (hasCode(kc, slots, keyOf(p, 4))) begin
          held[c][p]++;
          expFire[c][p] = (held[c][p] == 1) || (rep > 0 && ((held[c][p] - 1) % rep) == 0);
        end else begin
          held[c][p] = 0;
        end
      end
    end
  endtask

  task automatic resetModel();
    for (int c = 0; c < 2; c++) begin
      expDir[c]  = '0;
      expFire[c] = '0;
      held[c][0] = 0;
      held[c][1] = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkDirs(input string tag);
    checkOutput({tag, "_dir2p"}, 32'({move_fwd, move_back, rot_left, rot_right}), 32'(expDir[0]));
    checkOutput({tag, "_dir1p"}, 32'({1'b0, move_fwd1, 1'b0, move_back1, 1'b0, rot_left1, 1'b0, rot_right1}),
                32'(expDir[1]));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_tick"}, 32'({frame_tick1, frame_tick}), 32'(0));
    checkOutput({tag, "_fire"}, 32'({fire_pulse1, fire_pulse}), 32'(0));
    checkDirs(tag);
  endtask

  // One frame: keycode frameKc is stable across the tick, gapKc is present only between ticks.
  task automatic applyStimulus(input string tag, input logic [31:0] frameKc, input logic [31:0] gapKc);
    @(negedge Clk);
    keycode  = frameKc;
    frame_vs = 1'b0;
    @(negedge Clk);
    checkQuiet({tag, "_c1"});
    @(negedge Clk);
    checkQuiet({tag, "_c2"});
    @(negedge Clk);
    checkOutput({tag, "_tick"}, 32'({frame_tick1, frame_tick}), 32'(2'b11));
    checkDirs({tag, "_pre"});
    modelFrame(frameKc);
    @(negedge Clk);
    checkOutput({tag, "_fire"}, 32'({fire_pulse1, fire_pulse}), 32'({expFire[1][0], expFire[0]}));
    checkOutput({tag, "_tickoff"}, 32'({frame_tick1, frame_tick}), 32'(0));
    checkDirs({tag, "_post"});
    if (fire_pulse[0]) pulseCount++;
    @(negedge Clk);
    frame_vs = 1'b1;
    keycode  = gapKc;
    checkQuiet({tag, "_c5"});
    repeat (4) begin
      @(negedge Clk);
      checkQuiet({tag, "_gap"});
    end
  endtask

  initial begin
    logic [31:0] kc;
    logic [7:0]  pool [13];
    pool = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h28, 8'h01, 8'h33};

    Reset    = 1'b1;
    frame_vs = 1'b1;
    keycode  = 32'h1A2C5228;
    resetModel();

    repeat (3) begin
      @(negedge Clk);
      frame_vs = ~frame_vs;
      checkQuiet("reset");
    end
    Reset    = 1'b0;
    frame_vs = 1'b1;
    keycode  = 32'h0;
    @(negedge Clk);
    checkQuiet("first_after_reset");
    repeat (3) @(negedge Clk);

    applyStimulus("fwd", 32'h0000001A, 32'h0000001A);
    applyStimulus("fwd_hold", 32'h0000001A, 32'h0);
    applyStimulus("release", 32'h0, 32'h0);
    applyStimulus("conflict", 32'h00161A52, 32'h0);
    applyStimulus("rot_combo", 32'h07041A50, 32'h0);

    pulseCount = 0;
    repeat (20) applyStimulus("space_hold", 32'h0000002C, 32'h0000002C);
    checkOutput("space_pulse_count", 32'(pulseCount), 32'd3);
    applyStimulus("space_release", 32'h0, 32'h0);
    applyStimulus("space_repress", 32'h2C000000, 32'h0);

    applyStimulus("enter_between", 32'h0, 32'h00000028);
    applyStimulus("enter_gone", 32'h0, 32'h0);
    applyStimulus("enter_p1", 32'h00000028, 32'h0);

    applyStimulus("pre_rollover", 32'h00002C1A, 32'h0);
    applyStimulus("rollover", 32'h01010101, 32'h0);
    applyStimulus("post_rollover", 32'h00002C1A, 32'h0);

    applyStimulus("fire_a", 32'h2C1A2852, 32'h0);
    applyStimulus("fire_b", 32'h2C1A2852, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    resetModel();
    checkQuiet("midframe_reset");
    @(negedge Clk);
    checkQuiet("after_midframe_reset");
    applyStimulus("fire_after_reset", 32'h2C1A2852, 32'h0);

    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 4; s++) kc[8*s +: 8] = pool[$urandom_range(0, 12)];
      applyStimulus("random", kc, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
